// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// It allows one transaction in flight and bounds how long LS can starve IF.
//   state   | meaning
//   IDLE    | no transaction; arbitrate and grant combinationally
//   REQ     | request presented on the bus, waiting for mem_gnt_i
//   RESP    | bus accepted, waiting for mem_rvalid_i
module mem_port_arbiter #(
  parameter int XLEN          = 64,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [XLEN-1:0]     if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [XLEN-1:0]     if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [XLEN-1:0]     ls_addr_i,
  input  logic [XLEN-1:0]     ls_wdata_i,
  input  logic [XLEN/8-1:0]   ls_be_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [XLEN-1:0]     ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic                busy_o
);

  localparam int BEW = XLEN / 8;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              owner_ls_q, owner_ls_d;
  logic              owner_we_q, owner_we_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]    mem_be_q, mem_be_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   ls_rdata_q, ls_rdata_d;
  logic              grant_if, grant_ls;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      owner_ls_q  <= 1'b0;
      owner_we_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      owner_ls_q  <= owner_ls_d;
      owner_we_q  <= owner_we_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_if || grant_ls) state_d = ST_REQ;
      ST_REQ:  if (mem_gnt_i) state_d = ST_RESP;
      ST_RESP: if (mem_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Grants are suppressed during reset so nobody believes a request was taken.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (!rst && state_q == ST_IDLE) begin
      if (if_req_i && ls_req_i) begin
        if (streak_q == STREAK_MAX) grant_if = 1'b1;
        else                        grant_ls = 1'b1;
      end else begin
        grant_if = if_req_i;
        grant_ls = ls_req_i;
      end
    end
  end

  always_comb begin
    streak_d    = streak_q;
    owner_ls_d  = owner_ls_q;
    owner_we_d  = owner_we_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_ls) begin
          owner_ls_d  = 1'b1;
          owner_we_d  = ls_we_i;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we_i;
          mem_addr_d  = ls_addr_i;
          mem_wdata_d = ls_wdata_i;
          mem_be_d    = ls_be_i;
        end else if (grant_if) begin
          owner_ls_d  = 1'b0;
          owner_we_d  = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
        // Saturates at the limit; at the limit IF wins, so LS cannot push it further.
        if (!if_req_i || grant_if)
          streak_d = '0;
        else if (grant_ls && streak_q != STREAK_MAX)
          streak_d = streak_q + 4'd1;
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          if (owner_ls_q) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = owner_we_q ? '0 : mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    if_gnt_o    = grant_if;
    ls_gnt_o    = grant_ls;
    busy_o      = (state_q != ST_IDLE);
    mem_req_o   = mem_req_q;
    mem_we_o    = mem_we_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    mem_be_o    = mem_be_q;
    if_rvalid_o = if_rvalid_q;
    ls_rvalid_o = ls_rvalid_q;
    if_rdata_o  = if_rdata_q;
    ls_rdata_o  = ls_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int XLEN = 64;
  localparam int MAXS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_i, if_gnt_o, if_rvalid_o;
  logic [XLEN-1:0]   if_addr_i, if_rdata_o;
  logic              ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
  logic [XLEN-1:0]   ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic [7:0]        ls_be_i, mem_be_o;
  logic              mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [XLEN-1:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the single outstanding transaction and what each port last received.
  typedef struct packed {
    logic            ls;
    logic            store;
    logic [63:0]     addr;
    logic [63:0]     wdata;
    logic [7:0]      be;
  } txn_t;

  txn_t        cur;
  bit          pending, bus_took;
  int          streak;
  bit          exp_if_rv, exp_ls_rv;
  logic [63:0] exp_if_rd, exp_ls_rd;
  bit          if_taken, ls_taken;
  int          ls_run;

  task automatic cycle(input bit bus_rand, input int if_pct, input int ls_pct,
                       input int rst_pm, input bit starv);
    int w;
    @(posedge clk); #1;
    rst = ($urandom_range(0, 999) < rst_pm);
    if (!if_req_i || if_taken) begin
      if_req_i  = ($urandom_range(0, 99) < if_pct);
      if_addr_i = {$urandom, $urandom};
    end
    if (!ls_req_i || ls_taken) begin
      ls_req_i   = ($urandom_range(0, 99) < ls_pct);
      ls_we_i    = $urandom_range(0, 1) == 1;
      ls_addr_i  = {$urandom, $urandom};
      ls_wdata_i = {$urandom, $urandom};
      ls_be_i    = 8'($urandom);
    end
    if (bus_rand) begin
      mem_gnt_i    = ($urandom_range(0, 2) == 0);
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = {$urandom, $urandom};
    end else begin
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h0000_0000_DEAD_BEEF;
    end

    @(negedge clk);
    w = 0;
    if (!rst && !pending) begin
      if (if_req_i && ls_req_i) w = (streak >= MAXS) ? 1 : 2;
      else if (if_req_i)        w = 1;
      else if (ls_req_i)        w = 2;
    end
    check_eq("if_gnt", if_gnt_o, w == 1);
    check_eq("ls_gnt", ls_gnt_o, w == 2);
    check_eq("busy", busy_o, pending);
    check_eq("mem_req", mem_req_o, pending && !bus_took);
    check_eq("mem_we", mem_we_o, pending && !bus_took && cur.store);
    check_eq("mem_addr", mem_addr_o, cur.addr);
    check_eq("mem_wdata", mem_wdata_o, cur.wdata);
    check_eq("mem_be", mem_be_o, cur.be);
    check_eq("if_rvalid", if_rvalid_o, exp_if_rv);
    check_eq("ls_rvalid", ls_rvalid_o, exp_ls_rv);
    check_eq("if_rdata", if_rdata_o, exp_if_rd);
    check_eq("ls_rdata", ls_rdata_o, exp_ls_rd);
    if_taken = if_gnt_o;
    ls_taken = ls_gnt_o;

    // With both sides always requesting, LS gets exactly MAXS grants between IF grants.
    if (starv && !rst) begin
      if (w == 1) begin
        if (ls_run >= 0) check_eq("ls_streak_len", 64'(ls_run), 64'(MAXS));
        ls_run = 0;
      end else if (w == 2 && ls_run >= 0) begin
        ls_run++;
      end
    end
    if (rst) ls_run = -1;

    exp_if_rv = 1'b0;
    exp_ls_rv = 1'b0;
    if (rst) begin
      pending   = 1'b0;
      bus_took  = 1'b0;
      cur       = '0;
      streak    = 0;
      exp_if_rd = '0;
      exp_ls_rd = '0;
    end else if (!pending) begin
      if (w == 1) begin
        cur.ls = 1'b0; cur.store = 1'b0; cur.addr = if_addr_i;
        cur.wdata = '0; cur.be = 8'hFF;
      end else if (w == 2) begin
        cur.ls = 1'b1; cur.store = ls_we_i; cur.addr = ls_addr_i;
        cur.wdata = ls_wdata_i; cur.be = ls_be_i;
      end
      if (w != 0) begin
        pending  = 1'b1;
        bus_took = 1'b0;
      end
      if (!if_req_i || w == 1) streak = 0;
      else if (w == 2)         streak = (streak + 1 > MAXS) ? MAXS : streak + 1;
    end else if (!bus_took) begin
      if (mem_gnt_i) bus_took = 1'b1;
    end else if (mem_rvalid_i) begin
      pending = 1'b0;
      if (cur.ls) begin
        exp_ls_rv = 1'b1;
        exp_ls_rd = cur.store ? 64'd0 : mem_rdata_i;
      end else begin
        exp_if_rv = 1'b1;
        exp_if_rd = mem_rdata_i;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    pending = 1'b0; bus_took = 1'b0; cur = '0; streak = 0;
    exp_if_rv = 1'b0; exp_ls_rv = 1'b0; exp_if_rd = '0; exp_ls_rd = '0;
    if_taken = 1'b0; ls_taken = 1'b0; ls_run = -1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++)   cycle(1'b0, 100, 0, 0, 1'b0);
    ls_run = -1;
    for (int i = 0; i < 60; i++)   cycle(1'b0, 100, 100, 0, 1'b1);
    ls_run = -1;
    for (int i = 0; i < 3000; i++) cycle(1'b1, 50, 50, 5, 1'b0);
    ls_run = -1;
    for (int i = 0; i < 500; i++)  cycle(1'b1, 100, 100, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
